// File: rtl/ahb_gpio_irq.sv
// AHB-Lite zero-wait-state GPIO slave: per-port OUT/IN/IEN/ISTAT registers,
// synchronised inputs with change-detect interrupts (sticky, write-1-to-clear).
module ahb_gpio_irq #(
  parameter int          NPORT   = 2,
  parameter int          WIDTH   = 16,
  parameter logic [31:0] OUT_RST = 32'h0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic                   HREADY,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [31:0]            HWDATA,
  output logic [31:0]            HRDATA,
  output logic                   HREADYOUT,
  input  logic [NPORT*WIDTH-1:0] gpio_in,
  output logic [NPORT*WIDTH-1:0] gpio_out,
  output logic [NPORT-1:0]       irq,
  output logic                   irq_any
);

  logic [NPORT-1:0][WIDTH-1:0] r_out, r_ien, r_istat, r_sync1, r_sync2, r_hist;
  logic [NPORT-1:0][WIDTH-1:0] w_chg, w_clr;
  logic                        r_valid, r_write;
  logic [6:0]                  r_addr;
  logic [1:0]                  r_size;
  logic [1:0]                  r_cnt;
  logic                        w_armed, w_wr;
  logic [3:0]                  w_be;
  logic [31:0]                 w_wmask;
  logic [WIDTH-1:0]            w_m, w_d, w_rword;
  logic                        w_unused;

  assign HREADYOUT = 1'b1;
  assign gpio_out  = r_out;
  assign irq_any   = |irq;
  assign w_armed   = (r_cnt == 2'd3);
  assign w_wr      = r_valid & r_write;
  assign w_m       = w_wmask[WIDTH-1:0];
  assign w_d       = HWDATA[WIDTH-1:0];
  assign w_unused  = &{1'b0, HADDR[31:7], HSIZE[2], HTRANS[0], HWDATA, w_wmask};

  // Byte-lane enables for the registered write; HSIZE > word treated as word
  always_comb begin
    w_be = 4'hF;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_addr[1:0];
      2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'hF;
    endcase
    w_wmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  end

  always_comb begin
    w_chg = '0;
    w_clr = '0;
    irq   = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (w_armed) w_chg[p] = r_sync2[p] ^ r_hist[p];
      if (w_wr && r_addr[6:4] == 3'(p) && r_addr[3:2] == 2'd3) w_clr[p] = w_d & w_m;
      irq[p] = |(r_istat[p] & r_ien[p]);
    end
  end

  always_comb begin
    w_rword = '0;
    HRDATA  = '0;
    if (r_valid && !r_write) begin
      for (int p = 0; p < NPORT; p++) begin
        if (r_addr[6:4] == 3'(p)) begin
          case (r_addr[3:2])
            2'd0:    w_rword = r_out[p];
            2'd1:    w_rword = r_sync2[p];
            2'd2:    w_rword = r_ien[p];
            default: w_rword = r_istat[p];
          endcase
        end
      end
    end
    HRDATA[WIDTH-1:0] = w_rword;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= HSEL & HREADY & HTRANS[1];
      r_write <= HWRITE;
      r_addr  <= HADDR[6:0];
      r_size  <= HSIZE[1:0];
      if (!w_armed) r_cnt <= r_cnt + 2'd1;
    end
  end

  // Set beats clear on ISTAT: a change in the clearing cycle survives
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_out   <= {NPORT{OUT_RST[WIDTH-1:0]}};
      r_ien   <= '0;
      r_istat <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      for (int p = 0; p < NPORT; p++) begin
        if (w_wr && r_addr[6:4] == 3'(p) && r_addr[3:2] == 2'd0)
          r_out[p] <= (r_out[p] & ~w_m) | (w_d & w_m);
        if (w_wr && r_addr[6:4] == 3'(p) && r_addr[3:2] == 2'd2)
          r_ien[p] <= (r_ien[p] & ~w_m) | (w_d & w_m);
        r_istat[p] <= (r_istat[p] & ~w_clr[p]) | w_chg[p];
      end
    end
  end

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Scoreboard bench for ahb_gpio_irq (NPORT=2, WIDTH=16): stimulus queues expected
// values, a negedge monitor pops and compares on read data phases and signal checks.
module tb_ahb_gpio_irq;

  logic        HCLK, HRESETn, HSEL, HREADY, HWRITE, HREADYOUT, irq_any;
  logic [31:0] HADDR, HWDATA, HRDATA, gpio_in, gpio_out;
  logic [1:0]  HTRANS, irq;
  logic [2:0]  HSIZE;

  localparam logic [31:0] B = 32'h5000_0000;

  typedef struct {
    bit          is_rd;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rd_dph;
  logic [31:0] act;

  ahb_gpio_irq #(.NPORT(2), .WIDTH(16), .OUT_RST(32'h0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq), .irq_any(irq_any)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) rd_dph <= 1'b0;
    else          rd_dph <= HSEL & HREADY & HTRANS[1] & ~HWRITE;

  function automatic logic [31:0] get_sig(input int sel);
    case (sel)
      0:       return gpio_out;
      1:       return {30'b0, irq};
      2:       return {31'b0, irq_any};
      3:       return HRDATA;
      default: return {31'b0, HREADYOUT};
    endcase
  endfunction

  // Monitor: pops one expectation per negedge
  always @(negedge HCLK) begin
    if (rd_dph) begin
      if (q.size() == 0 || !q[0].is_rd) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_read got=%h", HRDATA);
      end else begin
        mon_e = q.pop_front();
        n_checks++;
        if (HRDATA !== mon_e.exp) begin
          n_fail++;
          $display("FAIL %s got=%h exp=%h", mon_e.name, HRDATA, mon_e.exp);
        end
      end
    end else if (q.size() != 0 && !q[0].is_rd) begin
      mon_e = q.pop_front();
      act = get_sig(mon_e.sel);
      n_checks++;
      if (act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s got=%h exp=%h", mon_e.name, act, mon_e.exp);
      end
    end
  end

  task automatic drain();
    int i = 0;
    while (q.size() != 0 && i < 20) begin
      @(negedge HCLK);
      i++;
    end
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout got=%0d pending exp=0", q.size());
      q.delete();
    end
  endtask

  // One bus cycle: address-phase fields plus HWDATA for the data phase in flight
  task automatic cyc(input bit v, input bit w, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd);
    HSEL = v; HTRANS = v ? 2'b10 : 2'b00; HADDR = a; HWRITE = w; HSIZE = sz; HWDATA = wd;
    @(posedge HCLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    cyc(1, 1, a, sz, 32'h0);
    cyc(0, 0, 32'h0, 3'd0, d);
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string n);
    q.push_back('{is_rd: 1'b1, sel: 0, exp: e, name: n});
    cyc(1, 0, a, 3'd2, 32'h0);
    cyc(0, 0, 32'h0, 3'd0, 32'h0);
    drain();
  endtask

  task automatic sig(input int sel, input logic [31:0] e, input string n);
    q.push_back('{is_rd: 1'b0, sel: sel, exp: e, name: n});
    drain();
  endtask

  initial begin
    HRESETn = 1'b0; HREADY = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = '0; HSIZE = '0; HWDATA = '0;
    gpio_in = 32'h0000_2345;
    repeat (3) @(posedge HCLK);
    #1;
    sig(0, 32'h0, "rst_gpio_out");
    sig(1, 32'h0, "rst_irq");
    sig(2, 32'h0, "rst_irq_any");
    sig(3, 32'h0, "rst_hrdata");
    sig(4, 32'h1, "rst_hreadyout");
    HRESETn = 1'b1;
    idle(5);

    // Word writes / reads
    bus_wr(B + 32'h00, 3'd2, 32'h1a2b_3c4d);
    bus_wr(B + 32'h10, 3'd2, 32'h1234_5678);
    bus_rd(B + 32'h00, 32'h0000_3c4d, "out0_word");
    bus_rd(B + 32'h10, 32'h0000_5678, "out1_word");
    sig(0, 32'h5678_3c4d, "gpio_out_word");

    // Byte/half lanes, IN is read-only
    bus_wr(B + 32'h01, 3'd0, 32'h0000_9000);
    bus_wr(B + 32'h10, 3'd0, 32'h0000_00ee);
    bus_wr(B + 32'h12, 3'd1, 32'hbeef_0000);
    bus_wr(B + 32'h04, 3'd0, 32'h0000_00ee);
    bus_wr(B + 32'h04, 3'd2, 32'hffff_ffff);
    bus_rd(B + 32'h00, 32'h0000_904d, "out0_byte");
    bus_rd(B + 32'h10, 32'h0000_56ee, "out1_byte_half");
    bus_rd(B + 32'h04, 32'h0000_2345, "in0_readonly");
    bus_rd(B + 32'h0C, 32'h0000_0000, "istat0_startup");

    // Change detect: 0x2345 ^ 0x4321 = 0x6064
    gpio_in = 32'h0000_4321;
    idle(3);
    bus_rd(B + 32'h04, 32'h0000_4321, "in0_new");
    bus_rd(B + 32'h0C, 32'h0000_6064, "istat0_chg");
    sig(1, 32'h0, "irq_ien_off");
    bus_wr(B + 32'h08, 3'd2, 32'h0000_0006);
    sig(1, 32'h1, "irq0_en");
    sig(2, 32'h1, "irq_any_en");
    bus_wr(B + 32'h0C, 3'd2, 32'h0000_0002);
    bus_rd(B + 32'h0C, 32'h0000_6064, "istat0_clr_unset");
    sig(1, 32'h1, "irq0_still");
    bus_wr(B + 32'h0C, 3'd2, 32'h0000_0004);
    bus_rd(B + 32'h0C, 32'h0000_6060, "istat0_clr");
    sig(1, 32'h0, "irq0_cleared");
    sig(2, 32'h0, "irq_any_cleared");

    // Bit 5 re-sets on the same edge the clear lands (pin -> sync -> sync -> hist)
    gpio_in = 32'h0000_4301;
    idle(1);
    cyc(1, 1, B + 32'h0C, 3'd2, 32'h0);
    cyc(0, 0, 32'h0, 3'd0, 32'h0000_0020);
    bus_rd(B + 32'h0C, 32'h0000_6060, "istat0_set_wins");
    bus_wr(B + 32'h0C, 3'd2, 32'h0000_0020);
    bus_rd(B + 32'h0C, 32'h0000_6040, "istat0_clr_bit5");

    // Unmapped ports
    for (int a = 32'h20; a < 32'h40; a += 4) bus_wr(B + 32'(a), 3'd2, 32'hffff_ffff);
    for (int a = 32'h20; a < 32'h40; a += 4) bus_rd(B + 32'(a), 32'h0, "unmapped_rd");
    sig(0, 32'h56ee_904d, "gpio_out_unmapped");
    sig(1, 32'h0, "irq_unmapped");
    bus_rd(B + 32'h08, 32'h0000_0006, "ien0_unmapped");

    // Back-to-back write then read of IEN1
    q.push_back('{is_rd: 1'b1, sel: 0, exp: 32'h0000_00ff, name: "ien1_b2b"});
    cyc(1, 1, B + 32'h18, 3'd2, 32'h0);
    cyc(1, 0, B + 32'h18, 3'd2, 32'h0000_00ff);
    cyc(0, 0, 32'h0, 3'd0, 32'h0);
    drain();

    // Port 1 change -> irq[1]
    gpio_in = 32'h0001_4301;
    idle(4);
    sig(1, 32'h2, "irq1_set");
    sig(2, 32'h1, "irq_any_port1");

    // Reset in a write data phase, pins held high through reset
    gpio_in = 32'hffff_ffff;
    cyc(1, 1, B + 32'h00, 3'd2, 32'h0);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0000_aaaa;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    sig(0, 32'h0, "rst_mid_gpio_out");
    sig(1, 32'h0, "rst_mid_irq");
    HRESETn = 1'b1;
    idle(6);
    bus_rd(B + 32'h00, 32'h0, "out0_after_rst");
    bus_rd(B + 32'h0C, 32'h0, "istat0_pins_high");
    bus_rd(B + 32'h1C, 32'h0, "istat1_pins_high");
    bus_rd(B + 32'h04, 32'h0000_ffff, "in0_pins_high");
    sig(2, 32'h0, "irq_any_after_rst");

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
